// File: rtl/channel_pkg.sv
// Shared constants and helpers for channel-attached stages (FIFOs, reducers).
package channel_pkg;

  localparam int unsigned CH_WIDTH = 32'd32;
  localparam int unsigned CH_DEPTH = 32'd8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    while ((32'd1 << r) < value) begin
      r = r + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register array storage for channel_fifo: synchronous write, asynchronous read.
module fifo_ram
  import channel_pkg::*;
#(
  parameter int unsigned WIDTH = CH_WIDTH,
  parameter int unsigned DEPTH = CH_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // storage write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/channel_fifo.sv
// Registered circular-buffer channel: pointers, occupancy, flags and the
// registered pop data; storage lives in fifo_ram.
module channel_fifo
  import channel_pkg::*;
#(
  parameter int unsigned WIDTH = CH_WIDTH,
  parameter int unsigned DEPTH = CH_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic                    read_valid,
  output logic                    read_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [clog2(DEPTH):0]   count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 32'd1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0]    wp_r;
  logic [AW-1:0]    rp_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] out_data_r;
  logic [CW-1:0]    count_next_s;
  logic [WIDTH-1:0] rdata_s;
  logic             push_s;
  logic             pop_s;
  logic             flush_s;

  // Flags come only from registered occupancy, so full+push and empty+pop
  // collisions resolve against start-of-cycle state.
  assign write_ready = (count_r != CNT_FULL);
  assign read_ready  = (count_r != {CW{1'b0}});
  assign flush_s     = rst | clr;
  assign push_s      = write_valid & write_ready & ~flush_s;
  assign pop_s       = read_valid & read_ready & ~flush_s;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wp_r),
    .wdata (in_data),
    .raddr (rp_r),
    .rdata (rdata_s)
  );

  // next occupancy from the accepted push/pop pair
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // pointer, occupancy and pop-data registers
  always_ff @(posedge clk) begin
    if (flush_s) begin
      wp_r       <= {AW{1'b0}};
      rp_r       <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
    end else begin
      count_r <= count_next_s;
      if (push_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (pop_s) begin
        rp_r       <= rp_r + PTR_ONE;
        out_data_r <= rdata_s;
      end
    end
  end

  assign out_data = out_data_r;
  assign count    = count_r;

endmodule

// File: tb/tb_channel_fifo.sv
// Scoreboard bench for channel_fifo: queue-based reference model, directed
// phases from the test plan plus randomized traffic.
module tb_channel_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [WIDTH-1:0]  in_data = 32'd0;
  logic              write_valid = 1'b0;
  logic              write_ready;
  logic              read_valid = 1'b0;
  logic              read_ready;
  logic [WIDTH-1:0]  out_data;
  logic [3:0]        count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] mq[$];      // model contents
  logic [WIDTH-1:0] exp_q[$];   // expected pop results
  logic [WIDTH-1:0] m_out = 32'd0;
  bit               chk_en = 1'b0;
  longint           red_sum = 0;

  channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .in_data     (in_data),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .out_data    (out_data),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, then advance the reference model.
  task automatic step(input logic wv, input logic [31:0] d, input logic rv,
                      input logic c, input logic r);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    write_valid = wv; in_data = d; read_valid = rv; clr = c; rst = r;
    @(posedge clk);
    if (r || c) begin
      mq.delete();
      m_out = 32'd0;
    end else begin
      do_pop  = rv && (mq.size() > 0);
      do_push = wv && (mq.size() < DEPTH);
      if (do_pop) begin
        m_out = mq.pop_front();
        exp_q.push_back(m_out);
      end
      if (do_push) mq.push_back(d);
    end
    if (r) chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: pop results against the scoreboard, flags/count every cycle.
  always begin
    bit ps;
    logic [WIDTH-1:0] e;
    @(posedge clk);
    ps = read_valid && read_ready && !rst && !clr;
    @(negedge clk);
    if (chk_en) begin
      if (ps) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", out_data, e);
          red_sum += out_data;
        end
      end
      chk("count", {28'd0, count}, mq.size());
      chk("write_ready", {31'd0, write_ready}, {31'd0, mq.size() != DEPTH});
      chk("read_ready", {31'd0, read_ready}, {31'd0, mq.size() != 0});
      chk("out_data_hold", out_data, m_out);
    end
  end

  initial begin
    int next;
    // reset
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    idle(1);

    // reducer pattern
    red_sum = 0;
    for (int i = 1; i <= 4; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      idle(2);
    end
    idle(1);
    chk("reducer_sum", red_sum[31:0], 32'd10);

    // fill and overflow
    for (int i = 0; i < 8; i++) step(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // simultaneous push/pop at full, then at count 3
    for (int i = 0; i < 8; i++) step(1'b1, 32'hB0 + i, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hEE, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // empty pop, then 20-word stream with wrap-around
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    next = 0;
    for (int cyc = 0; cyc < 400 && (next < 20 || mq.size() > 0); cyc++) begin
      logic wv;
      logic rv;
      wv = (next < 20) && (mq.size() < 5) && ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 1) != 0);
      step(wv, next, rv, 1'b0, 1'b0);
      if (wv) next++;
    end
    idle(1);
    chk("stream_complete", next + mq.size() * 100, 32'd20);

    // clear mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b1, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("clr_then_push_pop", out_data, 32'h55);

    // randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 1) != 0,
           $urandom_range(0, 49) == 0, 1'b0);
    end
    while (mq.size() > 0) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
